// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and helpers for the ALU execute pipe.
//   Opcode encodings (instr[24:21]), NZCV bit indices, and opcode class
//   helpers used by the combinational core.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Logical ops take C from the shifter and leave V alone.
    function automatic logic is_logical(input logic [3:0] op);
        case (op)
            OP_AND, OP_EOR, OP_TST, OP_TEQ,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN: is_logical = 1'b1;
            default:                        is_logical = 1'b0;
        endcase
    endfunction

    // Test ops update flags only; they never write Rd.
    function automatic logic is_test(input logic [3:0] op);
        is_test = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/alu_exec_core.sv
// alu_exec_core: purely combinational data-processing unit.
//   a, b      : operands (b already muxed between rm and operand2)
//   opcode    : 4-bit data-processing opcode
//   flags_cur : current NZCV register (C used as carry-in)
//   shift_c   : shifter carry-out, becomes C for logical ops
//   r         : WIDTH-bit result
//   nzcv_next : candidate NZCV value if this op sets flags
//   wr_en     : op writes Rd
module alu_exec_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic [3:0]       flags_cur,
    input  logic             shift_c,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       nzcv_next,
    output logic             wr_en
);

    logic [WIDTH-1:0] x, y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             cout, ovf;

    // Every arithmetic op reduces to x + y + cin with the inversions folded
    // into x/y, so a single adder covers all eight of them.
    always_comb begin
        x   = a;
        y   = b;
        cin = 1'b0;
        case (opcode)
            OP_SUB, OP_CMP: begin y = ~b;          cin = 1'b1;              end
            OP_RSB:         begin x = b;  y = ~a;  cin = 1'b1;              end
            OP_ADC:         begin                  cin = flags_cur[FLAG_C]; end
            OP_SBC:         begin y = ~b;          cin = flags_cur[FLAG_C]; end
            OP_RSC:         begin x = b;  y = ~a;  cin = flags_cur[FLAG_C]; end
            default:        ;
        endcase
    end

    assign sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign cout = sum[WIDTH];
    assign ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

    always_comb begin
        r = sum[WIDTH-1:0];
        case (opcode)
            OP_AND, OP_TST: r = a & b;
            OP_EOR, OP_TEQ: r = a ^ b;
            OP_ORR:         r = a | b;
            OP_MOV:         r = b;
            OP_BIC:         r = a & ~b;
            OP_MVN:         r = ~b;
            default:        ;
        endcase
    end

    always_comb begin
        nzcv_next         = flags_cur;
        nzcv_next[FLAG_N] = r[WIDTH-1];
        nzcv_next[FLAG_Z] = (r == '0);
        if (is_logical(opcode)) begin
            nzcv_next[FLAG_C] = shift_c;
        end else begin
            nzcv_next[FLAG_C] = cout;
            nzcv_next[FLAG_V] = ovf;
        end
    end

    assign wr_en = !is_test(opcode);

endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: ALU execute stage between decode and writeback.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : decode handshake; in_ready = buffer not full
//   imm_sel, opcode, set_flags, shift_c, rn, rm, operand2 : operation fields
//   out_valid/out_ready : writeback handshake on buffer head
//   result, wr_en     : head entry contents (zero when buffer empty)
//   flags             : architectural NZCV register
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             imm_sel,
    input  logic [3:0]       opcode,
    input  logic             set_flags,
    input  logic             shift_c,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] buf_result [BUF_DEPTH];
    logic             buf_wr     [BUF_DEPTH];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] core_r;
    logic [3:0]       core_nzcv;
    logic             core_wr;
    logic             push, pop;

    alu_exec_core #(.WIDTH(WIDTH)) u_core (
        .a         (rn),
        .b         (imm_sel ? operand2 : rm),
        .opcode    (opcode),
        .flags_cur (flags_q),
        .shift_c   (shift_c),
        .r         (core_r),
        .nzcv_next (core_nzcv),
        .wr_en     (core_wr)
    );

    // With depth 1 the pointer must stay at entry 0.
    function automatic logic ptr_inc(input logic p);
        ptr_inc = (BUF_DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    // Registered count only, so the decode side never sees a path from out_ready.
    assign in_ready  = (count < 2'(BUF_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign result = out_valid ? buf_result[rd_ptr] : '0;
    assign wr_en  = out_valid && buf_wr[rd_ptr];
    assign flags  = flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            flags_q <= 4'b0000;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_result[i] <= '0;
                buf_wr[i]     <= 1'b0;
            end
        end else begin
            if (push) begin
                buf_result[wr_ptr] <= core_r;
                buf_wr[wr_ptr]     <= core_wr;
                wr_ptr             <= ptr_inc(wr_ptr);
                if (set_flags) flags_q <= core_nzcv;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
module tb_alu_exec_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, imm_sel, set_flags, shift_c;
    logic [3:0]  opcode;
    logic [31:0] rn, rm, operand2;
    logic        out_valid, out_ready, wr_en;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_pipe #(.WIDTH(32), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm_sel(imm_sel), .opcode(opcode), .set_flags(set_flags), .shift_c(shift_c),
        .rn(rn), .rm(rm), .operand2(operand2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .wr_en(wr_en), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        in_valid = 1'b1; opcode = op; rn = a; rm = b; set_flags = s; imm_sel = 1'b0;
    endtask

    // Edge then settle; inputs changed after this are safely away from the edge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; imm_sel = 1'b0; opcode = 4'h0; set_flags = 1'b0;
        shift_c = 1'b0; rn = '0; rm = '0; operand2 = '0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,          32'd0);
        chk("rst_wr_en",     32'(wr_en),     32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // ADD overflow
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
        step(); in_valid = 1'b0;
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_result",    result,          32'h8000_0000);
        chk("add_flags",     32'(flags),     32'b1001);
        chk("add_wr_en",     32'(wr_en),     32'd1);
        step();
        chk("add_drained",   32'(out_valid), 32'd0);

        // CMP then SBC back-to-back: SBC sees C=1 from CMP
        drive(OP_CMP, 32'd5, 32'd5, 1'b1);
        step();
        chk("cmp_flags",  32'(flags), 32'b0110);
        chk("cmp_wr_en",  32'(wr_en), 32'd0);
        chk("cmp_result", result,      32'd0);
        drive(OP_SBC, 32'd3, 32'd1, 1'b1);
        step(); in_valid = 1'b0;
        chk("sbc_result", result,      32'd2);
        chk("sbc_flags",  32'(flags), 32'b0010);
        step();

        // SUB borrow then ADC with C=0
        drive(OP_SUB, 32'd0, 32'd1, 1'b1);
        step();
        chk("sub_result", result,      32'hFFFF_FFFF);
        chk("sub_flags",  32'(flags), 32'b1000);
        drive(OP_ADC, 32'd1, 32'd1, 1'b0);
        step(); in_valid = 1'b0;
        chk("adc_result", result,      32'd2);
        chk("adc_flags_kept", 32'(flags), 32'b1000);
        step();

        // Misc logical / reverse ops
        drive(OP_RSB, 32'd1, 32'd5, 1'b0);
        step(); chk("rsb_result", result, 32'd4);
        drive(OP_BIC, 32'h0000_F0F0, 32'h0000_00FF, 1'b0);
        step(); chk("bic_result", result, 32'h0000_F000);
        drive(OP_MVN, 32'hDEAD_BEEF, 32'h0, 1'b0);
        step(); chk("mvn_result", result, 32'hFFFF_FFFF);
        drive(OP_TEQ, 32'h5, 32'h5, 1'b0);
        step(); in_valid = 1'b0;
        chk("teq_wr_en", 32'(wr_en), 32'd0);
        chk("teq_flags_kept", 32'(flags), 32'b1000);
        step();

        // Backpressure: three ops, only two fit
        out_ready = 1'b0;
        drive(OP_ADD, 32'd10, 32'd1, 1'b0);
        step(); chk("bp_ready1", 32'(in_ready), 32'd1);
        drive(OP_ADD, 32'd20, 32'd1, 1'b0);
        step(); chk("bp_ready2", 32'(in_ready), 32'd0);
        drive(OP_ADD, 32'd30, 32'd1, 1'b0);
        step();
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_head0",       result,          32'd11);
        out_ready = 1'b1;
        step();
        chk("bp_head1",  result, 32'd21);
        step(); in_valid = 1'b0;
        chk("bp_head2",  result, 32'd31);
        chk("bp_valid2", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty",  32'(out_valid), 32'd0);

        // Streaming: simultaneous push and pop keeps occupancy at one
        drive(OP_ADD, 32'd40, 32'd1, 1'b0);
        step();
        drive(OP_ADD, 32'd50, 32'd1, 1'b0);
        step();
        chk("stream_head",  result,          32'd51);
        chk("stream_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        step();
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Reset with two buffered ops
        out_ready = 1'b0;
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
        step();
        drive(OP_MOV, 32'h0, 32'h5, 1'b0);
        step(); in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_flags",     32'(flags),     32'd0);
        chk("rst2_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;

        // MOV immediate keeps prior V, takes C from shifter
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
        step();
        drive(OP_MOV, 32'h1234_5678, 32'h0, 1'b1);
        imm_sel = 1'b1; operand2 = 32'hFF; shift_c = 1'b1;
        step(); in_valid = 1'b0; imm_sel = 1'b0; shift_c = 1'b0;
        chk("mov_result", result,      32'h0000_00FF);
        chk("mov_flags",  32'(flags), 32'b0011);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
